// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, IO) arbiter in front of a single-port
// synchronous memory. One access at a time, three cycles per access
// (IDLE grant -> ACCESS -> RESPOND). Ties go to the requester named by a
// round-robin priority pointer, which flips to the loser after every access.
//
// Handshake: a requester raises xx_Req with stable WE/Addr/WData and holds it
// until it sees xx_Ack, a single-cycle pulse in the RESPOND cycle. The command
// is captured at the grant edge, so later changes on the request inputs do not
// affect the access in flight. A Req still high when the arbiter is back in
// IDLE is a new request. For reads, xx_RData carries the data in the Ack cycle
// and keeps it until that requester's next read completes.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    // CPU requester
    input  logic              CPU_Req,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_Addr,
    input  logic [DATA_W-1:0] CPU_WData,
    output logic              CPU_Ack,
    output logic [DATA_W-1:0] CPU_RData,
    // IO requester
    input  logic              IO_Req,
    input  logic              IO_WE,
    input  logic [ADDR_W-1:0] IO_Addr,
    input  logic [DATA_W-1:0] IO_WData,
    output logic              IO_Ack,
    output logic [DATA_W-1:0] IO_RData,
    // Memory port
    output logic              Mem_En,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData,
    // Status and debug visibility
    output logic              Busy,
    output logic [1:0]        dbg_state,
    output logic              dbg_pri
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    // Grant decision made in IDLE this cycle
    logic                grant;
    logic                grant_io;

    // Command of the selected requester, captured on grant
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Latched access in flight
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                win_io_q;

    // Round-robin pointer: 0 favours CPU, 1 favours IO on a tie
    logic                pri_q;

    // Read-data holding registers and read-completion strobes
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   io_rdata_q;
    logic                cpu_rd_done;
    logic                io_rd_done;

    // State register; reset wins over any request in the same cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, grant decision, memory strobes and acknowledges
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_io    = 1'b0;
        Mem_En      = 1'b0;
        Mem_WE      = 1'b0;
        CPU_Ack     = 1'b0;
        IO_Ack      = 1'b0;
        cpu_rd_done = 1'b0;
        io_rd_done  = 1'b0;
        case (state)
            IDLE: begin
                if (CPU_Req && IO_Req) begin
                    grant    = 1'b1;
                    grant_io = pri_q;
                end else if (CPU_Req) begin
                    grant    = 1'b1;
                    grant_io = 1'b0;
                end else if (IO_Req) begin
                    grant    = 1'b1;
                    grant_io = 1'b1;
                end
                if (grant) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                Mem_En     = 1'b1;
                Mem_WE     = we_q;
                state_next = RESPOND;
            end
            RESPOND: begin
                // A reset landing on the RESPOND cycle aborts the access, so
                // the acknowledge and the read-data bypass are suppressed.
                if (!Reset) begin
                    CPU_Ack     = ~win_io_q;
                    IO_Ack      = win_io_q;
                    cpu_rd_done = ~win_io_q & ~we_q;
                    io_rd_done  = win_io_q & ~we_q;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Select the command of whichever requester is being granted
    always_comb begin
        sel_we    = CPU_WE;
        sel_addr  = CPU_Addr;
        sel_wdata = CPU_WData;
        if (grant_io) begin
            sel_we    = IO_WE;
            sel_addr  = IO_Addr;
            sel_wdata = IO_WData;
        end
    end

    // Capture the granted command; it drives the memory port and holds after
    always_ff @(posedge Clock) begin
        if (Reset) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            win_io_q <= 1'b0;
        end else if (grant) begin
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            win_io_q <= grant_io;
        end
    end

    // Hand priority to the loser once an access completes
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pri_q <= 1'b0;
        end else if (state == RESPOND) begin
            pri_q <= ~win_io_q;
        end
    end

    // Hold the most recent read data of each requester
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            if (cpu_rd_done) begin
                cpu_rdata_q <= Mem_RData;
            end
            if (io_rd_done) begin
                io_rdata_q <= Mem_RData;
            end
        end
    end

    // Memory data arrives in RESPOND; bypass it so RData is valid with Ack
    always_comb begin
        CPU_RData = cpu_rd_done ? Mem_RData : cpu_rdata_q;
        IO_RData  = io_rd_done  ? Mem_RData : io_rdata_q;
    end

    // Memory address/data follow the latched command and hold between accesses
    always_comb begin
        Mem_Addr  = addr_q;
        Mem_WData = wdata_q;
    end

    // Status and debug outputs
    always_comb begin
        Busy      = (state != IDLE);
        dbg_state = state;
        dbg_pri   = pri_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-level
// reference model, a per-cycle compare process, a grant-order scoreboard and
// literal expectations for the key scenarios.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    always #5 Clock = ~Clock;

    logic          CPU_Req = 1'b0, CPU_WE = 1'b0;
    logic [AW-1:0] CPU_Addr = '0;
    logic [DW-1:0] CPU_WData = '0;
    logic          CPU_Ack;
    logic [DW-1:0] CPU_RData;
    logic          IO_Req = 1'b0, IO_WE = 1'b0;
    logic [AW-1:0] IO_Addr = '0;
    logic [DW-1:0] IO_WData = '0;
    logic          IO_Ack;
    logic [DW-1:0] IO_RData;
    logic          Mem_En, Mem_WE;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WData;
    logic [DW-1:0] Mem_RData = '0;
    logic          Busy;
    logic [1:0]    dbg_state;
    logic          dbg_pri;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock(Clock), .Reset(Reset),
        .CPU_Req(CPU_Req), .CPU_WE(CPU_WE), .CPU_Addr(CPU_Addr), .CPU_WData(CPU_WData),
        .CPU_Ack(CPU_Ack), .CPU_RData(CPU_RData),
        .IO_Req(IO_Req), .IO_WE(IO_WE), .IO_Addr(IO_Addr), .IO_WData(IO_WData),
        .IO_Ack(IO_Ack), .IO_RData(IO_RData),
        .Mem_En(Mem_En), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_RData(Mem_RData), .Busy(Busy), .dbg_state(dbg_state), .dbg_pri(dbg_pri)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    int we_cnt   = 0;
    int ack_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory preload pattern shared by the environment and the model
    function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
        return 16'hA5A5 ^ {6'd0, a};
    endfunction

    // ---------------- environment memory (1-cycle read latency) ----------------
    logic [DW-1:0] mem_arr [int];

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem_arr.exists(int'(a)) ? mem_arr[int'(a)] : preload(a);
    endfunction

    always @(posedge Clock) begin
        if (Mem_En === 1'b1) begin
            if (Mem_WE === 1'b1) mem_arr[int'(Mem_Addr)] = Mem_WData;
            else                 Mem_RData <= mem_rd(Mem_Addr);
        end
    end

    // ---------------- reference model ----------------
    // Transaction view: a granted access is "age 1" in the cycle after the
    // grant (memory strobe), "age 2" in the next (acknowledge), then done.
    int            m_age    = 0;
    logic          m_io     = 1'b0;
    logic          m_we     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic          m_pri    = 1'b0;
    logic [DW-1:0] m_cpu_rd = '0;
    logic [DW-1:0] m_io_rd  = '0;
    logic [AW-1:0] m_maddr  = '0;
    logic [DW-1:0] m_mwdata = '0;
    logic [DW-1:0] m_shadow [int];
    logic [0:0]    exp_q[$];

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return m_shadow.exists(int'(a)) ? m_shadow[int'(a)] : preload(a);
    endfunction

    always @(posedge Clock) begin
        cyc++;
        // The write strobe was up during the cycle just ended, reset or not
        if (m_age == 1 && m_we) m_shadow[int'(m_addr)] = m_wdata;
        if (Reset) begin
            m_age = 0; m_pri = 1'b0; m_cpu_rd = '0; m_io_rd = '0;
            m_maddr = '0; m_mwdata = '0; m_we = 1'b0;
            exp_q.delete();
        end else if (m_age == 2) begin
            if (!m_we) begin
                if (m_io) m_io_rd  = shadow_rd(m_addr);
                else      m_cpu_rd = shadow_rd(m_addr);
            end
            m_pri = ~m_io;
            m_age = 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (CPU_Req || IO_Req) begin
            m_io    = IO_Req && (!CPU_Req || m_pri);
            m_we    = m_io ? IO_WE    : CPU_WE;
            m_addr  = m_io ? IO_Addr  : CPU_Addr;
            m_wdata = m_io ? IO_WData : CPU_WData;
            m_maddr = m_addr; m_mwdata = m_wdata;
            m_age   = 1;
            exp_q.push_back(m_io);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clock) begin
        logic          e_cack, e_iack;
        logic [DW-1:0] e_crd, e_ird;
        if (Mem_WE === 1'b1) we_cnt++;
        if (CPU_Ack === 1'b1) ack_log.push_back(0);
        if (IO_Ack === 1'b1)  ack_log.push_back(1);
        if (chk_en) begin
            e_cack = (m_age == 2) && !m_io && !Reset;
            e_iack = (m_age == 2) &&  m_io && !Reset;
            e_crd  = (e_cack && !m_we) ? shadow_rd(m_addr) : m_cpu_rd;
            e_ird  = (e_iack && !m_we) ? shadow_rd(m_addr) : m_io_rd;
            check("busy",      Busy,      m_age != 0);
            check("mem_en",    Mem_En,    m_age == 1);
            check("mem_we",    Mem_WE,    (m_age == 1) && m_we);
            check("mem_addr",  Mem_Addr,  m_maddr);
            check("mem_wdata", Mem_WData, m_mwdata);
            check("cpu_ack",   CPU_Ack,   e_cack);
            check("io_ack",    IO_Ack,    e_iack);
            check("cpu_rdata", CPU_RData, e_crd);
            check("io_rdata",  IO_RData,  e_ird);
            check("pri",       dbg_pri,   m_pri);
            check("one_ack",   CPU_Ack & IO_Ack, 1'b0);
            if (CPU_Ack === 1'b1 || IO_Ack === 1'b1) begin
                if (exp_q.size() == 0) check("ack_unexpected", 1, 0);
                else                   check("ack_owner", IO_Ack, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input bit io, output int n, output bit seen);
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge Clock);
            n++;
            seen = io ? IO_Ack : CPU_Ack;
        end
    endtask

    task automatic access(input bit io, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                          output int lat, output int ack_cyc);
        bit seen;
        @(posedge Clock); #1;
        if (io) begin IO_Req = 1'b1; IO_WE = we; IO_Addr = addr; IO_WData = wdata; end
        else    begin CPU_Req = 1'b1; CPU_WE = we; CPU_Addr = addr; CPU_WData = wdata; end
        wait_ack(io, lat, seen);
        rdata   = io ? IO_RData : CPU_RData;
        ack_cyc = cyc;
        if (!seen) check(io ? "io_ack_timeout" : "cpu_ack_timeout", 0, 1);
        @(posedge Clock); #1;
        if (io) begin IO_Req = 1'b0; IO_WE = 1'b0; end
        else    begin CPU_Req = 1'b0; CPU_WE = 1'b0; end
    endtask

    task automatic pulse_reset();
        @(posedge Clock); #1 Reset = 1'b1;
        @(posedge Clock); #1 Reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [DW-1:0] rd_c, rd_i;
        int            lat_c, lat_i, ack_c, ack_i, n;
        bit            seen;

        repeat (3) @(posedge Clock);
        #1 chk_en = 1'b1;
        @(negedge Clock);
        check("rst_busy",      Busy, 1'b0);
        check("rst_cpu_rdata", CPU_RData, 16'h0000);
        check("rst_io_rdata",  IO_RData,  16'h0000);
        check("rst_mem_addr",  Mem_Addr,  10'h000);
        check("rst_pri",       dbg_pri,   1'b0);
        @(posedge Clock); #1 Reset = 1'b0;

        // Idle bus: nothing moves for 10 cycles
        repeat (10) begin
            @(negedge Clock);
            check("idle_en",   Mem_En, 1'b0);
            check("idle_busy", Busy, 1'b0);
            check("idle_acks", {CPU_Ack, IO_Ack}, 2'b00);
        end

        // CPU write then read back of the same word
        we_cnt = 0;
        access(1'b0, 1'b1, 10'h005, 16'hBEEF, rd_c, lat_c, ack_c);
        check("wr_we_cycles", we_cnt, 1);
        access(1'b0, 1'b0, 10'h005, 16'h0000, rd_c, lat_c, ack_c);
        check("rd_data_beef", rd_c, 16'hBEEF);
        check("rd_latency",   lat_c, 3);
        check("rd_no_we",     we_cnt, 1);

        // Simultaneous reads after reset: CPU first, IO three cycles later
        pulse_reset();
        fork
            access(1'b0, 1'b0, 10'h005, 16'h0000, rd_c, lat_c, ack_c);
            access(1'b1, 1'b0, 10'h010, 16'h0000, rd_i, lat_i, ack_i);
        join
        check("tie_cpu_lat",  lat_c, 3);
        check("tie_io_gap",   ack_i - ack_c, 3);
        check("tie_cpu_data", rd_c, 16'hBEEF);
        check("tie_io_data",  rd_i, 16'hA5B5);

        // Both hold Req for 12 cycles: grants alternate CPU, IO, CPU, IO
        ack_log.delete();
        @(posedge Clock); #1;
        CPU_Req = 1'b1; CPU_WE = 1'b0; CPU_Addr = 10'h005;
        IO_Req  = 1'b1; IO_WE  = 1'b0; IO_Addr  = 10'h020;
        repeat (12) @(posedge Clock);
        #1 CPU_Req = 1'b0; IO_Req = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        check("rr_grants", ack_log.size(), 4);
        for (int i = 0; i < ack_log.size(); i++) check("rr_order", ack_log[i], i % 2);
        check("rr_io_data", IO_RData, 16'hA585);

        // IO write; inputs change after the grant and must be ignored
        @(posedge Clock); #1;
        IO_Req = 1'b1; IO_WE = 1'b1; IO_Addr = 10'h3FF; IO_WData = 16'h1234;
        @(posedge Clock); #1;
        IO_Addr = 10'h000; IO_WData = 16'h0F0F;
        wait_ack(1'b1, n, seen);
        if (!seen) check("io_wr_ack_timeout", 0, 1);
        @(posedge Clock); #1 IO_Req = 1'b0; IO_WE = 1'b0;
        check("wr_lands_3ff",   mem_rd(10'h3FF), 16'h1234);
        check("wr_spares_000",  mem_rd(10'h000), 16'hA5A5);
        check("io_rdata_held",  IO_RData, 16'hA585);

        // CPU-only read leaves priority pointing at IO
        access(1'b0, 1'b0, 10'h010, 16'h0000, rd_c, lat_c, ack_c);
        check("pri_to_io", dbg_pri, 1'b1);

        // Reset in ACCESS of a CPU write, Req kept high through reset
        @(posedge Clock); #1;
        CPU_Req = 1'b1; CPU_WE = 1'b1; CPU_Addr = 10'h0AA; CPU_WData = 16'h5555;
        @(posedge Clock); #1 Reset = 1'b1;
        @(negedge Clock);
        check("abort_in_access", {Busy, Mem_WE}, 2'b11);
        repeat (2) begin
            @(negedge Clock);
            check("abort_we",   Mem_WE,  1'b0);
            check("abort_busy", Busy,    1'b0);
            check("abort_pri",  dbg_pri, 1'b0);
            check("abort_ack",  CPU_Ack, 1'b0);
        end
        @(posedge Clock); #1;
        Reset = 1'b0; CPU_Req = 1'b0; CPU_WE = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            check("abort_no_late_ack", CPU_Ack, 1'b0);
        end

        // Recovery: CPU reads the word the IO wrote
        access(1'b0, 1'b0, 10'h3FF, 16'h0000, rd_c, lat_c, ack_c);
        check("recover_data", rd_c, 16'h1234);
        check("recover_lat",  lat_c, 3);
        repeat (3) @(posedge Clock);
        #1;
        check("recover_rdata_hold", CPU_RData, 16'h1234);
        check("scoreboard_empty",   exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
